// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data-RAM port: one request at a time, with optional
// splitting of misaligned half/word accesses into little-endian byte beats.
module lsu_mem_master #(
   parameter bit          ALLOW_MISALIGNED = 1'b1,
   parameter int unsigned ADDR_W           = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_hb_i,
   input  logic              req_uload_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              mem_we_o,
   output logic [1:0]        mem_hb_o,
   output logic              mem_uload_o,
   input  logic [31:0]       mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q, uload_q, split_q, err_q;
   logic [1:0]          hb_q, cnt_q, last_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q, asm_q;
   logic                accept, misaligned, reject, last_beat;
   logic [7:0]          wbyte;

   assign accept     = (state_q == IDLE) && req_valid_i;
   assign misaligned = ((req_hb_i == 2'b10) && req_addr_i[0]) ||
                       ((req_hb_i == 2'b00) && (req_addr_i[1:0] != 2'b00));
   assign reject     = (req_hb_i == 2'b11) || (misaligned && !ALLOW_MISALIGNED);
   assign last_beat  = !split_q || (cnt_q == last_q);
   assign wbyte      = wdata_q[{cnt_q, 3'b000} +: 8];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_valid_i) state_d = reject ? RESP : ACCESS;
         ACCESS:  if (last_beat) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         uload_q <= 1'b0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         hb_q    <= 2'b11;
         cnt_q   <= '0;
         last_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we_i;
            uload_q <= req_uload_i;
            hb_q    <= req_hb_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            err_q   <= reject;
            split_q <= misaligned && !reject;
            last_q  <= (req_hb_i == 2'b10) ? 2'd1 : 2'd3;
            cnt_q   <= '0;
            asm_q   <= '0;
         end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 2'd1;
            if (split_q) asm_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i[7:0];
            else         asm_q <= mem_rdata_i;
         end
      end
   end

   // Split beats are byte reads with uload=1, so half-word extension happens here;
   // aligned accesses rely on the RAM's own extension.
   always_comb begin
      req_ready_o = (state_q == IDLE);
      rsp_valid_o = (state_q == RESP);
      rsp_err_o   = (state_q == RESP) && err_q;
      rsp_rdata_o = '0;
      if ((state_q == RESP) && !err_q && !we_q) begin
         if (split_q && (hb_q == 2'b10))
            rsp_rdata_o = {{16{~uload_q & asm_q[15]}}, asm_q[15:0]};
         else
            rsp_rdata_o = asm_q;
      end
   end

   // Write enable is masked while reset is held so an abandoned beat never commits.
   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_we_o    = 1'b0;
      mem_hb_o    = 2'b11;
      mem_uload_o = 1'b0;
      if (state_q == ACCESS) begin
         mem_we_o = we_q & ~rst_i;
         if (split_q) begin
            mem_addr_o  = addr_q + ADDR_W'(cnt_q);
            mem_wdata_o = {24'h0, wbyte};
            mem_hb_o    = 2'b01;
            mem_uload_o = 1'b1;
         end else begin
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            mem_hb_o    = hb_q;
            mem_uload_o = uload_q;
         end
      end
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit: the initiator side of the data-RAM port.
- Accepts one load/store request at a time from the core's memory stage over a valid/ready handshake.
- Drives the RAM's address/wdata/we/half-byte/uload bus and returns a response with loaded data.
- Misaligned accesses are split into sequential byte accesses, then reassembled and sign/zero-extended locally.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split misaligned half/word accesses into byte accesses; 0 = reject them with err.
- ADDR_W, 32: width of the request and memory address.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_we_i  in  1  1 = store, 0 = load
- req_hb_i  in  2  size: 00 word, 01 byte, 10 half, 11 reserved
- req_uload_i  in  1  zero-extend the load
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores
- rsp_err_o  out  1  valid with rsp_valid_o: misaligned (when ALLOW_MISALIGNED=0) or reserved size
- mem_addr_o  out  ADDR_W  byte address to RAM
- mem_wdata_o  out  32  store data, right-aligned
- mem_we_o  out  1  RAM write enable
- mem_hb_o  out  2  RAM size: 00 word, 01 byte, 10 half, 11 no access
- mem_uload_o  out  1  RAM unsigned-load select
- mem_rdata_i  in  32  combinational RAM read data

Behaviour:
- RAM model: read data is combinational in the cycle the address is driven; a write commits at the posedge ending the cycle with mem_we_o=1.
- Reset (rst_i at a posedge) forces:
  - state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0;
  - mem_we_o=0, mem_hb_o=11, mem_addr_o=0, mem_wdata_o=0, mem_uload_o=0.
- Reset mid-operation abandons the transaction: no further mem cycles and no response. Bytes already written stay written.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - On valid & ready, latch we/hb/uload/addr/wdata and compute misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - Reserved size, or misaligned with ALLOW_MISALIGNED=0: go to RESP with err=1 and no mem access.
  - Otherwise: cnt=0; N=1 if aligned, else N=2 (half) or N=4 (word); go to ACCESS.
- ACCESS, aligned (N=1):
  - mem_addr_o=addr, mem_hb_o=req hb, mem_uload_o=uload, mem_we_o=we, mem_wdata_o=wdata.
  - Loads capture mem_rdata_i at the end of the cycle.
- ACCESS, split (N>1), one byte per cycle, k=cnt:
  - mem_addr_o=addr+k, wrapping modulo 2^ADDR_W.
  - mem_hb_o=01, mem_uload_o=1, mem_wdata_o={24'b0, wdata[8k+7:8k]}, mem_we_o=we.
  - Loads capture mem_rdata_i[7:0] into assembly byte k (little-endian).
  - cnt increments each cycle; go to RESP after k=N-1.
- Outside ACCESS: mem_hb_o=11 and mem_we_o=0, always.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. Response contents:
  - aligned load: rdata = captured word;
  - split load: half → {16{uload?0:b1[7]}, b1, b0}; word → {b3, b2, b1, b0};
  - store or error: rdata = 0.
- Latency from the accept edge:
  - aligned: rsp_valid_o 2 cycles later;
  - split: N+1 cycles later;
  - error: 1 cycle later.
- Throughput: a new request can be accepted the cycle after RESP. No back-to-back overlap.
- Inputs are ignored outside IDLE; the request fields latched at accept are used throughout.

Test Plan:
- Aligned word store 0xDEADBEEF @0x10, then word load @0x10 → one mem cycle each (hb=00); load rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
- Byte store 0x80 @0x21, signed byte load → 0xFFFFFF80; same load with uload=1 → 0x00000080; mem_hb_o=01, mem_addr_o=0x21.
- Misaligned word store 0x11223344 @0x03 → 4 byte writes 0x44,0x33,0x22,0x11 at 0x03..0x06; word load @0x03 returns 0x11223344 after 5 cycles.
- Misaligned half load @0x05 with bytes 0x05=0x34, 0x06=0x92 → signed 0xFFFF9234, uload 0x00009234; ALLOW_MISALIGNED=0 → rsp_err_o=1, rdata=0, mem_hb_o stays 11.
- rst_i asserted during the 2nd byte of a misaligned word store @0x0A → byte 0x0A written, nothing further written, no rsp_valid; req_ready_o=1 the cycle after reset.
- Address wrap: misaligned half load @0xFFFFFFFF → mem_addr_o sequence 0xFFFFFFFF, 0x00000000.
